// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory byte loader: the loader
// state encoding, the instruction memory depth and the bytes per word.
// No ports.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    localparam int IMEM_DEPTH = 6000;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the loader's byte-stream handshake and the instruction memory
// write port.
//   in_valid / in_data : byte offered by the host
//   in_ready           : loader takes the byte this cycle
//   mem_we             : one-cycle write strobe per word
//   mem_addr           : word index into instruction memory
//   mem_wdata          : assembled little-endian word
// Modports: master = host / memory side, slave = loader side.
interface imem_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer
// Collects accepted bytes into a 32-bit word, little-endian: the first byte
// of a word lands in bits 7:0, the fourth in bits 31:24.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart at lane 0 (held while the loader is idle)
//   accept     : a byte transfers this cycle
//   data       : the byte
//   word       : the lanes as currently assembled
//   word_done  : the byte accepted this cycle completes the word
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0] byte_idx_reg;

    // The index wraps naturally at WORD_BYTES, so no explicit modulo.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx_reg <= '0;
        end else if (accept) begin
            byte_idx_reg <= byte_idx_reg + IDX_W'(1);
        end
    end

    assign word_done = accept && (byte_idx_reg == IDX_W'(WORD_BYTES - 1));

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (accept && (byte_idx_reg == IDX_W'(gi))) begin
                    lane_reg <= data;
                end
            end

            assign word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Byte-stream programming port for the instruction memory. Bytes arrive over
// a valid/ready handshake, are packed little-endian into words, and each word
// is written at consecutive word addresses starting at a programmable base.
//   clk, reset             : clock and synchronous active-high reset
//   start                  : begin a load (only honoured while idle)
//   base_addr, word_count  : load window, captured with start
//   bus (slave)            : byte stream in, memory write port out
//   busy                   : a load is in progress
//   done                   : one-cycle pulse when a load completes
//   error                  : sticky; range violation or checksum mismatch,
//                            cleared by the next accepted start
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the data words a
// 4-byte checksum (32-bit modular sum of the words) is read and compared;
// it is never written to memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic [31:0]   word_count,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_WRITE  = ST_WRITE;
    localparam logic [2:0] S_FINISH = ST_FINISH;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK  = ST_CHECK;
`endif

    logic [2:0]  state_reg, state_next;
    logic [31:0] base_reg, base_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] written_reg, written_next;
    logic        error_reg, error_next;
    logic        empty_reg, empty_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum_reg, sum_next;
`endif

    logic [31:0] packed_word;
    logic        word_done;
    logic        accept;

    assign accept = bus.in_valid && bus.in_ready;

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_reg == S_IDLE),
        .accept    (accept),
        .data      (bus.in_data),
        .word      (packed_word),
        .word_done (word_done)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.in_ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
`else
    assign bus.in_ready = (state_reg == S_LOAD);
`endif
    // The write strobe is masked by reset so a word completed just before
    // reset never reaches memory.
    assign bus.mem_we    = (state_reg == S_WRITE) && !reset;
    assign bus.mem_addr  = base_reg + written_reg;
    assign bus.mem_wdata = packed_word;

    assign busy  = (state_reg != S_IDLE);
    // An empty load spends one extra FINISH cycle (empty_reg) so its done
    // pulse lands two cycles after start.
    assign done  = (state_reg == S_FINISH) && !empty_reg;
    assign error = error_reg;

    always_comb begin
        state_next   = state_reg;
        base_next    = base_reg;
        count_next   = count_reg;
        written_next = written_reg;
        error_next   = error_reg;
        empty_next   = empty_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_next     = sum_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    base_next    = base_addr;
                    count_next   = word_count;
                    written_next = '0;
                    error_next   = 1'b0;
                    empty_next   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_next     = '0;
`endif
                    if (word_count == 32'd0) begin
                        state_next = S_FINISH;
                        empty_next = 1'b1;
                    end else if (({1'b0, base_addr} + {1'b0, word_count}) > 33'(DEPTH)) begin
                        // 33-bit sum so a huge base or count cannot wrap past the check.
                        error_next = 1'b1;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (word_done) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                written_next = written_reg + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_next     = sum_reg + packed_word;
`endif
                if (written_reg + 32'd1 == count_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_FINISH;
`endif
                end else begin
                    state_next = S_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The last checksum byte is still on the bus, not yet in the lanes.
                if (word_done) begin
                    if ({bus.in_data, packed_word[23:0]} != sum_reg) begin
                        error_next = 1'b1;
                    end
                    state_next = S_FINISH;
                end
            end
`endif
            S_FINISH: begin
                if (empty_reg) begin
                    empty_next = 1'b0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            base_reg    <= '0;
            count_reg   <= '0;
            written_reg <= '0;
            error_reg   <= 1'b0;
            empty_reg   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            base_reg    <= base_next;
            count_reg   <= count_next;
            written_reg <= written_next;
            error_reg   <= error_next;
            empty_reg   <= empty_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. A cycle-level model of the load
// (bytes still owed, pending write, done countdown, sticky error) is checked
// against the DUT every cycle; directed loads are then pinned with literal
// addresses, data words and done timing. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] word_count;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader_if bus ();

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        wr_log[$];
    int         done_cyc    = -1;
    int         last_we_cyc = -1;
    int         start_cyc   = -1;
    logic [7:0] bq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit          m_active = 1'b0;
    bit          m_wpend  = 1'b0;
    bit          m_err    = 1'b0;
    int          m_bytes_left = 0;
    int          m_words_left = 0;
    int          m_done_cd    = 0;
    int          m_lane       = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_sum  = '0;

    always @(negedge clk) begin
        bit exp_done;
        bit exp_rdy;
        bit was_active;
        if (reset) begin
            chk("mem_we_in_reset", {31'd0, bus.mem_we}, 32'd0);
            m_active     = 1'b0;
            m_wpend      = 1'b0;
            m_err        = 1'b0;
            m_bytes_left = 0;
            m_words_left = 0;
            m_done_cd    = 0;
            m_lane       = 0;
        end else begin
            was_active = m_active;
            exp_done   = (m_done_cd == 1);
            if (m_done_cd > 0) m_done_cd--;
            exp_rdy = m_active && (m_bytes_left > 0) && !m_wpend;

            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
            chk("mem_we",   {31'd0, bus.mem_we},   {31'd0, m_wpend});
            chk("done",     {31'd0, done},         {31'd0, exp_done});
            chk("busy",     {31'd0, busy},         {31'd0, m_active});
            chk("error",    {31'd0, error},        {31'd0, m_err});

            if (bus.mem_we) begin
                wr_log.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
                last_we_cyc = cyc;
                $display("write addr=%0d data=0x%08h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
            end
            if (done) done_cyc = cyc;

            if (m_wpend) begin
                chk("mem_addr",  bus.mem_addr,  m_addr);
                chk("mem_wdata", bus.mem_wdata, m_word);
                m_addr  = m_addr + 32'd1;
                m_sum   = m_sum + m_word;
                m_words_left--;
                m_wpend = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (m_words_left == 0) m_done_cd = 1;
`endif
            end

            if (exp_rdy && bus.in_valid) begin
                m_word[8*m_lane +: 8] = bus.in_data;
                m_lane = (m_lane + 1) % 4;
                m_bytes_left--;
                if (m_lane == 0) begin
                    if (m_words_left > 0) begin
                        m_wpend = 1'b1;
                    end else begin
                        if (m_word != m_sum) m_err = 1'b1;
                        m_done_cd = 1;
                    end
                end
            end

            if (exp_done) m_active = 1'b0;

            if (start && !was_active) begin
                m_err = 1'b0;
                if (word_count == 32'd0) begin
                    m_active  = 1'b1;
                    m_done_cd = 2;
                end else if (longint'(base_addr) + longint'(word_count) > 64'd6000) begin
                    m_err = 1'b1;
                end else begin
                    m_active     = 1'b1;
                    m_words_left = int'(word_count);
                    m_bytes_left = 4 * int'(word_count);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_bytes_left = m_bytes_left + 4;
`endif
                    m_addr = base_addr;
                    m_sum  = '0;
                    m_lane = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] c);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        start_cyc  = cyc;
        $display("start base=%0d count=%0d cycle=%0d", b, c, cyc);
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        int n;
        for (int g = 0; g < gaps; g++) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("handshake_timeout", {31'd0, bus.in_ready}, 32'd1);
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 500) begin
                chk("idle_timeout", {31'd0, busy}, 32'd0);
                break;
            end
        end
        tick();
    endtask

    task automatic add4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        bq.push_back(b0);
        bq.push_back(b1);
        bq.push_back(b2);
        bq.push_back(b3);
    endtask

    task automatic run_load(input logic [31:0] b, input int n, input bit rnd, input bit bad_ck);
        logic [31:0] s;
        logic [31:0] w;
        s = '0;
        do_start(b, n);
        foreach (bq[i]) send_byte(bq[i], rnd ? int'($urandom_range(0, 3)) : 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < n; i++) begin
            w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            s = s + w;
        end
        if (bad_ck) s = s + 32'd1;
        for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8], 0);
`else
        w = {31'd0, bad_ck};
        s = w;
`endif
        wait_idle();
    endtask

    task automatic chk_wr(input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wr_log.size()) begin
            chk("log_addr", wr_log[i].a, a);
            chk("log_data", wr_log[i].d, d);
        end else begin
            chk("log_missing", wr_log.size(), i + 1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, bus.mem_we},   32'd0);
        chk({tag, "_mem_addr"},  bus.mem_addr,          32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,         32'd0);
        chk({tag, "_busy"},      {31'd0, busy},         32'd0);
        chk({tag, "_done"},      {31'd0, done},         32'd0);
        chk({tag, "_error"},     {31'd0, error},        32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n0;
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        word_count   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_reset_outputs("por");

        // Two words from base 0, back-to-back bytes.
        n0 = wr_log.size();
        bq.delete();
        add4(8'h78, 8'h56, 8'h34, 8'h12);
        add4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
        run_load(32'd0, 2, 1'b0, 1'b0);
        chk("t1_nwrites", wr_log.size() - n0, 32'd2);
        chk_wr(n0,     32'd0, 32'h1234_5678);
        chk_wr(n0 + 1, 32'd1, 32'hDEAD_BEEF);
        chk("t1_done_lat", done_cyc - last_we_cyc, 32'd1);
        repeat (3) tick();
        chk("t1_no_more", wr_log.size() - n0, 32'd2);

        // Out-of-range window: error, no activity.
        n0 = wr_log.size();
        do_start(32'd5990, 32'd20);
        tick();
        chk("t2_error", {31'd0, error}, 32'd1);
        chk("t2_busy",  {31'd0, busy},  32'd0);
        chk("t2_nwrites", wr_log.size() - n0, 32'd0);

        // Exactly fits the top of memory; also clears the error.
        bq.delete();
        add4(8'h01, 8'h02, 8'h03, 8'h04);
        add4(8'h05, 8'h06, 8'h07, 8'h08);
        run_load(32'd5998, 2, 1'b0, 1'b0);
        chk("t2b_error_clr", {31'd0, error}, 32'd0);
        chk_wr(n0,     32'd5998, 32'h0403_0201);
        chk_wr(n0 + 1, 32'd5999, 32'h0807_0605);

        // One word past the end, and a 32-bit wrapping window.
        n0 = wr_log.size();
        do_start(32'd5999, 32'd2);
        tick();
        chk("t2c_error", {31'd0, error}, 32'd1);
        do_start(32'hFFFF_FFFF, 32'd2);
        tick();
        chk("t2d_error", {31'd0, error}, 32'd1);
        chk("t2d_nwrites", wr_log.size() - n0, 32'd0);

        // Zero-length load.
        n0 = wr_log.size();
        do_start(32'd7, 32'd0);
        wait_idle();
        chk("t3_done_lat", done_cyc - start_cyc, 32'd2);
        chk("t3_nwrites", wr_log.size() - n0, 32'd0);
        chk("t3_error_clr", {31'd0, error}, 32'd0);

        // Gappy byte stream, three words at base 100.
        n0 = wr_log.size();
        bq.delete();
        add4(8'h11, 8'h12, 8'h13, 8'h14);
        add4(8'h15, 8'h16, 8'h17, 8'h18);
        add4(8'h19, 8'h1A, 8'h1B, 8'h1C);
        run_load(32'd100, 3, 1'b1, 1'b0);
        chk("t4_nwrites", wr_log.size() - n0, 32'd3);
        chk_wr(n0,     32'd100, 32'h1413_1211);
        chk_wr(n0 + 1, 32'd101, 32'h1817_1615);
        chk_wr(n0 + 2, 32'd102, 32'h1C1B_1A19);

        // Reset after 6 of 8 bytes.
        n0 = wr_log.size();
        do_start(32'd200, 32'd2);
        send_byte(8'h21, 0);
        send_byte(8'h22, 0);
        send_byte(8'h23, 0);
        send_byte(8'h24, 0);
        send_byte(8'h25, 0);
        send_byte(8'h26, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("t5");
        chk("t5_nwrites", wr_log.size() - n0, 32'd1);
        chk_wr(n0, 32'd200, 32'h2423_2221);

        // 4th byte accepted in the reset cycle is never written.
        n0 = wr_log.size();
        do_start(32'd400, 32'd1);
        send_byte(8'h51, 0);
        send_byte(8'h52, 0);
        send_byte(8'h53, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h54;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("t5b_nwrites", wr_log.size() - n0, 32'd0);

        // Reset during the write cycle suppresses the strobe.
        do_start(32'd500, 32'd1);
        send_byte(8'h61, 0);
        send_byte(8'h62, 0);
        send_byte(8'h63, 0);
        send_byte(8'h64, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t5c_nwrites", wr_log.size() - n0, 32'd0);

        // Loader is usable again after reset.
        bq.delete();
        add4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        run_load(32'd300, 1, 1'b0, 1'b0);
        chk("t5d_nwrites", wr_log.size() - n0, 32'd1);
        chk_wr(n0, 32'd300, 32'hA4A3_A2A1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Words 1,2,3 with checksum 6, then with checksum 7.
        n0 = wr_log.size();
        bq.delete();
        add4(8'h01, 8'h00, 8'h00, 8'h00);
        add4(8'h02, 8'h00, 8'h00, 8'h00);
        add4(8'h03, 8'h00, 8'h00, 8'h00);
        run_load(32'd10, 3, 1'b0, 1'b0);
        chk("t6_error_ok", {31'd0, error}, 32'd0);
        chk("t6_nwrites", wr_log.size() - n0, 32'd3);
        chk_wr(n0 + 2, 32'd12, 32'd3);
        n0 = wr_log.size();
        run_load(32'd10, 3, 1'b0, 1'b1);
        chk("t6_error_bad", {31'd0, error}, 32'd1);
        chk("t6_nwrites_bad", wr_log.size() - n0, 32'd3);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
